stack_game_ctrl: RTL and testbench
==================================

Name: stack_game_ctrl

Overview:
- Parametrised next-generation gameplay FSM for the block-stacking game; drives the gameplay datapath (x/y/direction/difficulty registers) and the display FSM.
- Generalises the single-row controller. Configurable tower height, chance count and difficulty ramp.
- Internal row, score, chance and difficulty counters, graded overlap scoring, working pause, and distinct win/lose end states.

Parameters:
- NUM_ROWS, 16, tower height in rows; reaching row NUM_ROWS-1 successfully wins.
- MAX_CHANCES, 3, chances at start; also the cap for bonus chances.
- BLOCK_MAX, 40, full block width in pixels; overlap equal to this is "perfect".
- OV_W, 6, width of overlap_w; must satisfy 2^OV_W > BLOCK_MAX.
- SCORE_W, 10, score width.
- DF_STEP, 4, rows per difficulty step.
- DF_MAX, 3, maximum difficulty level.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- place  in  1  place-block key, level; internally rising-edge detected
- pause  in  1  pause switch, level
- overlap_w  in  OV_W  overlap width of current vs previous block, from datapath; valid in JUDGE
- ld_x, ld_y, ld_d, ld_df  out  1 each  parallel-load strobes to datapath
- enable  out  1  block shift enable
- save_x  out  1  latch current x as previous x
- row  out  clog2(NUM_ROWS)  current row index
- score  out  SCORE_W  current score
- chances  out  clog2(MAX_CHANCES+1)  remaining chances
- difficulty  out  clog2(DF_MAX+1)  current level
- game_status  out  2  00 paused, 01 playing, 10 lost, 11 won

Behaviour:
- The one-bit register place_q captures place each cycle. place_pulse = place & ~place_q. A held key produces exactly one pulse.
- States: PREP, MOVE, PAUSED, JUDGE, SUCCESS, FAIL, WIN, LOSE.
- Strobes are Moore-decoded from the state. Unlisted strobes are 0.
- Reset (any state, mid-game included) takes effect at the next edge:
  - state=PREP, row=0, score=0, chances=MAX_CHANCES, difficulty=0, place_q=0.
  - Decode during reset: ld_x=ld_y=ld_d=ld_df=1, enable=0, save_x=0, game_status=01.
- PREP: ld_x, ld_y, ld_d, ld_df=1. Registers difficulty=min(row/DF_STEP, DF_MAX). Next state is MOVE.
- MOVE: enable=1.
  - pause=1 goes to PAUSED. Pause has priority over a same-cycle place_pulse, and that pulse is discarded.
  - Otherwise place_pulse goes to JUDGE. JUDGE is entered on the edge after the pulse cycle, so latency is 1 cycle.
- PAUSED: enable=0, game_status=00. pause=0 returns to MOVE. place_pulse is ignored.
- JUDGE: enable=0. Samples overlap_w.
  - row==0: always SUCCESS, scored as a partial hit.
  - overlap_w==0: FAIL.
  - Otherwise SUCCESS.
- SUCCESS: save_x=1.
  - Score increment: partial adds difficulty+1; perfect (overlap_w>=BLOCK_MAX) adds 2*(difficulty+1) and grants chances+1, saturating at MAX_CHANCES.
  - Score saturates at 2^SCORE_W-1.
  - row==NUM_ROWS-1 goes to WIN (row is held). Otherwise row+1, then PREP.
- FAIL: ld_x=1, ld_d=1; chances-1.
  - If the pre-decrement value was 1, go to LOSE (chances=0).
  - Otherwise go to MOVE on the same row.
  - The chance decrement occurs only here, never in SUCCESS.
- WIN: game_status=11. LOSE: game_status=10. Counters are frozen in both.
  - place_pulse clears row, score and difficulty, sets chances=MAX_CHANCES, and goes to PREP.
- Illegal state encodings recover to PREP.
- game_status=01 in all states not listed above.

Test Plan:
1. Reset, hold place high 10 cycles -> exactly one JUDGE visit; row 0->1; score=1; chances=3; ld_* high in PREP cycles only.
2. Row 3, place with overlap_w=0, three times -> chances 3->2->1->0, then game_status=10; a fourth place_pulse restarts with score=0, chances=3.
3. overlap_w=40 at row 5 (difficulty 1) with chances=2 -> score +4, chances=3; repeat with chances=3 -> chances stays 3.
4. Pause asserted in MOVE on the same cycle as a place edge -> PAUSED, enable=0, status 00, no JUDGE; release -> MOVE, enable=1.
5. NUM_ROWS=4, four successful placements -> game_status=11 after the fourth; row=3; further inputs frozen until place_pulse.
6. Reset asserted during SUCCESS with score=9 -> next cycle PREP, score=0, row=0, no save_x pulse after reset.

Source files
------------

// File: rtl/stack_game_ctrl.sv
// Gameplay controller for the block-stacking game: sequences the datapath load/shift strobes
// and keeps the row, score, chance and difficulty counters for a configurable tower.
module stack_game_ctrl #(
    parameter int unsigned NUM_ROWS    = 16,
    parameter int unsigned MAX_CHANCES = 3,
    parameter int unsigned BLOCK_MAX   = 40,
    parameter int unsigned OV_W        = 6,
    parameter int unsigned SCORE_W     = 10,
    parameter int unsigned DF_STEP     = 4,
    parameter int unsigned DF_MAX      = 3,
    localparam int unsigned ROW_W      = $clog2(NUM_ROWS),
    localparam int unsigned CH_W       = $clog2(MAX_CHANCES + 1),
    localparam int unsigned DF_W       = $clog2(DF_MAX + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               place,
    input  logic               pause,
    input  logic [OV_W-1:0]    overlap_w,
    output logic               ld_x,
    output logic               ld_y,
    output logic               ld_d,
    output logic               ld_df,
    output logic               enable,
    output logic               save_x,
    output logic [ROW_W-1:0]   row,
    output logic [SCORE_W-1:0] score,
    output logic [CH_W-1:0]    chances,
    output logic [DF_W-1:0]    difficulty,
    output logic [1:0]         game_status
);

    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(NUM_ROWS - 1);
    localparam logic [CH_W-1:0]    CH_FULL    = CH_W'(MAX_CHANCES);
    localparam logic [OV_W-1:0]    PERFECT_OV = OV_W'(BLOCK_MAX);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    typedef enum logic [2:0] {
        StPrep    = 3'd0,
        StMove    = 3'd1,
        StPaused  = 3'd2,
        StJudge   = 3'd3,
        StSuccess = 3'd4,
        StFail    = 3'd5,
        StWin     = 3'd6,
        StLose    = 3'd7
    } state_e;

    state_e state_q, state_d;

    logic               place_q;
    logic               place_pulse;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [CH_W-1:0]    chances_q, chances_d;
    logic [DF_W-1:0]    diff_q, diff_d;
    logic               perfect_q, perfect_d;

    logic [31:0]        df_raw;
    logic [DF_W-1:0]    df_target;
    logic [SCORE_W:0]   score_inc;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;

    assign place_pulse = place & ~place_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            place_q <= 1'b0;
        end else begin
            place_q <= place;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StPrep;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StPrep: state_d = StMove;
            StMove: begin
                // A place edge coinciding with pause is dropped, not deferred.
                if (pause) begin
                    state_d = StPaused;
                end else if (place_pulse) begin
                    state_d = StJudge;
                end
            end
            StPaused: begin
                if (!pause) begin
                    state_d = StMove;
                end
            end
            StJudge: begin
                if (row_q != '0 && overlap_w == '0) begin
                    state_d = StFail;
                end else begin
                    state_d = StSuccess;
                end
            end
            StSuccess: state_d = (row_q == LAST_ROW) ? StWin : StPrep;
            StFail:    state_d = (chances_q == CH_W'(1)) ? StLose : StMove;
            StWin, StLose: begin
                if (place_pulse) begin
                    state_d = StPrep;
                end
            end
            default: state_d = StPrep;
        endcase
    end

    // Outputs decode from the state; reset forces the PREP decode in the reset cycle itself.
    always_comb begin
        ld_x        = 1'b0;
        ld_y        = 1'b0;
        ld_d        = 1'b0;
        ld_df       = 1'b0;
        enable      = 1'b0;
        save_x      = 1'b0;
        game_status = 2'b01;
        if (reset) begin
            ld_x  = 1'b1;
            ld_y  = 1'b1;
            ld_d  = 1'b1;
            ld_df = 1'b1;
        end else begin
            case (state_q)
                StPrep: begin
                    ld_x  = 1'b1;
                    ld_y  = 1'b1;
                    ld_d  = 1'b1;
                    ld_df = 1'b1;
                end
                StMove:    enable = 1'b1;
                StPaused:  game_status = 2'b00;
                StSuccess: save_x = 1'b1;
                StFail: begin
                    ld_x = 1'b1;
                    ld_d = 1'b1;
                end
                StWin:   game_status = 2'b11;
                StLose:  game_status = 2'b10;
                default: ;
            endcase
        end
    end

    // Difficulty ramps one level every DF_STEP rows, capped at DF_MAX.
    always_comb begin
        df_raw = 32'(row_q) / DF_STEP;
        if (df_raw > DF_MAX) begin
            df_raw = DF_MAX;
        end
        df_target = DF_W'(df_raw);
    end

    // Perfect placements are worth double and the score saturates rather than wraps.
    always_comb begin
        score_inc = (SCORE_W + 1)'(diff_q) + (SCORE_W + 1)'(1);
        if (perfect_q) begin
            score_inc = score_inc << 1;
        end
        score_sum = {1'b0, score_q} + score_inc;
        score_sat = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[SCORE_W-1:0];
    end

    always_comb begin
        row_d     = row_q;
        score_d   = score_q;
        chances_d = chances_q;
        diff_d    = diff_q;
        perfect_d = perfect_q;
        case (state_q)
            StPrep:  diff_d = df_target;
            // The base row is always scored as a partial hit.
            StJudge: perfect_d = (row_q != '0) && (overlap_w >= PERFECT_OV);
            StSuccess: begin
                score_d = score_sat;
                if (perfect_q && chances_q < CH_FULL) begin
                    chances_d = chances_q + CH_W'(1);
                end
                if (row_q != LAST_ROW) begin
                    row_d = row_q + ROW_W'(1);
                end
            end
            StFail: chances_d = chances_q - CH_W'(1);
            StWin, StLose: begin
                if (place_pulse) begin
                    row_d     = '0;
                    score_d   = '0;
                    chances_d = CH_FULL;
                    diff_d    = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q     <= '0;
            score_q   <= '0;
            chances_q <= CH_FULL;
            diff_q    <= '0;
            perfect_q <= 1'b0;
        end else begin
            row_q     <= row_d;
            score_q   <= score_d;
            chances_q <= chances_d;
            diff_q    <= diff_d;
            perfect_q <= perfect_d;
        end
    end

    assign row        = row_q;
    assign score      = score_q;
    assign chances    = chances_q;
    assign difficulty = diff_q;

endmodule

// File: tb/tb_stack_game_ctrl.sv
// Randomised bench for stack_game_ctrl: a game-rule model predicts the counters and play phase
// each time the controller settles; a monitor checks them in order from a scoreboard queue.
module tb_stack_game_ctrl;

    localparam int unsigned NR  = 10;
    localparam int unsigned MC  = 3;
    localparam int unsigned BM  = 40;
    localparam int unsigned OVW = 6;
    localparam int unsigned SW  = 5;
    localparam int unsigned DS  = 2;
    localparam int unsigned DM  = 3;
    localparam int unsigned RW  = $clog2(NR);
    localparam int unsigned CW  = $clog2(MC + 1);
    localparam int unsigned DW  = $clog2(DM + 1);

    // Settled phases: 1 moving, 2 paused, 3 lost, 4 won; 0 means transient.
    localparam int PH_MOVE  = 1;
    localparam int PH_PAUSE = 2;
    localparam int PH_LOST  = 3;
    localparam int PH_WON   = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           place;
    logic           pause;
    logic [OVW-1:0] overlap_w;
    logic           ld_x, ld_y, ld_d, ld_df, enable, save_x;
    logic [RW-1:0]  row;
    logic [SW-1:0]  score;
    logic [CW-1:0]  chances;
    logic [DW-1:0]  difficulty;
    logic [1:0]     game_status;

    stack_game_ctrl #(
        .NUM_ROWS   (NR),
        .MAX_CHANCES(MC),
        .BLOCK_MAX  (BM),
        .OV_W       (OVW),
        .SCORE_W    (SW),
        .DF_STEP    (DS),
        .DF_MAX     (DM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .place      (place),
        .pause      (pause),
        .overlap_w  (overlap_w),
        .ld_x       (ld_x),
        .ld_y       (ld_y),
        .ld_d       (ld_d),
        .ld_df      (ld_df),
        .enable     (enable),
        .save_x     (save_x),
        .row        (row),
        .score      (score),
        .chances    (chances),
        .difficulty (difficulty),
        .game_status(game_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        int score;
        int ch;
        int df;
        int phase;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;
    int   prev_phase = 0;
    bit   abort = 1'b0;

    int m_row, m_score, m_ch, m_df;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int phase_now();
        if (enable) return PH_MOVE;
        case (game_status)
            2'b00:   return PH_PAUSE;
            2'b10:   return PH_LOST;
            2'b11:   return PH_WON;
            default: return 0;
        endcase
    endfunction

    task automatic push_exp(input int ph);
        exp_t e;
        e.row   = m_row;
        e.score = m_score;
        e.ch    = m_ch;
        e.df    = m_df;
        e.phase = ph;
        sb_q.push_back(e);
    endtask

    task automatic model_reset();
        m_row   = 0;
        m_score = 0;
        m_ch    = MC;
        m_df    = 0;
    endtask

    // One judged placement in game-rule terms.
    task automatic model_place(input int ov);
        bit perfect;
        int inc;
        if (m_row != 0 && ov == 0) begin
            m_ch = m_ch - 1;
            push_exp((m_ch == 0) ? PH_LOST : PH_MOVE);
        end else begin
            perfect = (m_row != 0) && (ov >= BM);
            inc     = (m_df + 1) * (perfect ? 2 : 1);
            m_score = imin(m_score + inc, (1 << SW) - 1);
            if (perfect) m_ch = imin(m_ch + 1, MC);
            if (m_row == NR - 1) begin
                push_exp(PH_WON);
            end else begin
                m_row = m_row + 1;
                m_df  = imin(m_row / DS, DM);
                push_exp(PH_MOVE);
            end
        end
    endtask

    // Monitor: checks the reset decode, and pops one expectation per newly settled phase.
    always @(negedge clk) begin
        int   ph;
        exp_t e;
        if (reset) begin
            chk("reset_ld", int'({ld_x, ld_y, ld_d, ld_df}), 15);
            chk("reset_en_save", int'({enable, save_x}), 0);
            chk("reset_status", int'(game_status), 1);
            ph = 0;
        end else begin
            ph = phase_now();
        end
        if (ph != 0 && ph != prev_phase) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_settle_phase", ph, 0);
            end else begin
                e = sb_q.pop_front();
                chk("phase", ph, e.phase);
                chk("row", int'(row), e.row);
                chk("score", int'(score), e.score);
                chk("chances", int'(chances), e.ch);
                chk("difficulty", int'(difficulty), e.df);
            end
        end
        prev_phase = ph;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!reset && (enable || game_status[1])) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    function automatic int pick_overlap();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) return 0;
        if (r < 6) return $urandom_range(BM, (1 << OVW) - 1);
        return $urandom_range(1, BM - 1);
    endfunction

    task automatic press_and_release();
        int h;
        h = $urandom_range(1, 5);
        repeat (h) tick();
        place = 1'b0;
        tick();
    endtask

    task automatic do_place();
        int ov;
        repeat ($urandom_range(0, 2)) begin
            overlap_w = OVW'($urandom_range(0, (1 << OVW) - 1));
            tick();
        end
        ov        = pick_overlap();
        overlap_w = OVW'(ov);
        place     = 1'b1;
        model_place(ov);
        press_and_release();
    endtask

    task automatic do_pause();
        pause = 1'b1;
        place = 1'($urandom_range(0, 1));
        push_exp(PH_PAUSE);
        repeat ($urandom_range(1, 4)) begin
            tick();
            place = 1'($urandom_range(0, 1));
        end
        place = 1'b0;
        tick();
        pause = 1'b0;
        push_exp(PH_MOVE);
        tick();
    endtask

    // Reset lands while the placement is in JUDGE or in SUCCESS/FAIL.
    task automatic do_reset();
        overlap_w = OVW'(pick_overlap());
        place     = 1'b1;
        tick();
        repeat ($urandom_range(0, 1)) tick();
        reset = 1'b1;
        place = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
        model_reset();
        push_exp(PH_MOVE);
        reset = 1'b0;
        tick();
    endtask

    task automatic do_restart();
        repeat ($urandom_range(0, 4)) begin
            pause     = 1'($urandom_range(0, 1));
            overlap_w = OVW'($urandom_range(0, (1 << OVW) - 1));
            tick();
        end
        pause = 1'b0;
        tick();
        place = 1'b1;
        model_reset();
        push_exp(PH_MOVE);
        press_and_release();
    endtask

    initial begin
        bit ok;
        int sel;
        reset     = 1'b1;
        place     = 1'b0;
        pause     = 1'b0;
        overlap_w = '0;
        repeat (3) tick();
        model_reset();
        push_exp(PH_MOVE);
        reset = 1'b0;
        tick();

        for (int t = 0; t < 400; t++) begin
            wait_ready(ok);
            if (!ok) begin
                chk("ready_timeout", 0, 1);
                abort = 1'b1;
                break;
            end
            if (game_status[1]) begin
                do_restart();
            end else begin
                sel = $urandom_range(0, 99);
                if (sel < 70) begin
                    do_place();
                end else if (sel < 88) begin
                    do_pause();
                end else begin
                    do_reset();
                end
            end
        end

        if (!abort) begin
            wait_ready(ok);
            chk("final_ready", int'(ok), 1);
            repeat (3) tick();
            chk("scoreboard_drained", sb_q.size(), 0);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
